// File: rtl/quotient_multiplier.sv
// quotient_multiplier: sequential shift-add multiply-accumulate, A = Q*D + R.
// Rebuilds a divider dividend from quotient, divisor and remainder. One
// operation in flight at a time; start/done handshake, fixed DW-cycle latency.
// Optional feature macro: QMULT_REMCHK_EN adds the remerr output (R >= D).
module quotient_multiplier #(
  parameter int QW = 6,   // quotient / remainder width
  parameter int DW = 5,   // divisor width and iteration count
  parameter int AW = 10   // dividend width for the overflow flag (AW <= QW+DW)
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             start,
  input  logic [QW-1:0]    QIN,
  input  logic [DW-1:0]    DIN,
  input  logic [QW-1:0]    RIN,
  output logic             busy,
  output logic             done,
  output logic [QW+DW-1:0] AOUT,
  output logic             overflow
`ifdef QMULT_REMCHK_EN
  ,
  output logic             remerr
`endif
);

  localparam int PW = QW + DW;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  // 2^AW held one bit wider than the product so AW == PW stays representable.
  localparam logic [PW:0] LIMIT = {{PW{1'b0}}, 1'b1} << AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   p;        // running accumulator, seeded with R
  logic [PW-1:0]   m;        // shifted multiplicand (Q * 2^i)
  logic [DW-1:0]   b;        // multiplier bits still to consume
  logic [CW-1:0]   cnt;      // iteration index within CALC
  logic [PW-1:0]   p_nxt;
  logic            last_iter;

`ifdef QMULT_REMCHK_EN
  logic [QW-1:0]   r_q;      // latched remainder for the range check
  logic [DW-1:0]   d_q;      // latched divisor for the range check
`endif

  assign last_iter = (cnt == CW'(DW - 1));

  // Accumulator value after the current iteration's conditional add.
  always_comb begin
    p_nxt = p;
    if (b[0]) p_nxt = p + m;
  end

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and handshake outputs; code 3 falls back to IDLE with outputs low.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and result registration.
  // NOTE: all datapath flops are reset so an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p        <= '0;
      m        <= '0;
      b        <= '0;
      cnt      <= '0;
      AOUT     <= '0;
      overflow <= 1'b0;
`ifdef QMULT_REMCHK_EN
      r_q      <= '0;
      d_q      <= '0;
      remerr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p   <= PW'(RIN);
            m   <= PW'(QIN);
            b   <= DIN;
            cnt <= '0;
`ifdef QMULT_REMCHK_EN
            r_q <= RIN;
            d_q <= DIN;
`endif
          end
        end
        CALC: begin
          p   <= p_nxt;
          m   <= m << 1;
          b   <= b >> 1;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            AOUT     <= p_nxt;
            overflow <= ({1'b0, p_nxt} >= LIMIT);
`ifdef QMULT_REMCHK_EN
            remerr   <= (PW'(r_q) >= PW'(d_q));
`endif
          end
        end
        DONE: ;
        default: begin
          AOUT     <= '0;
          overflow <= 1'b0;
`ifdef QMULT_REMCHK_EN
          remerr   <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_multiplier.sv
// tb_quotient_multiplier: directed self-checking bench for quotient_multiplier.
// Define QMULT_REMCHK_EN for both files to exercise the remerr output.
module tb_quotient_multiplier;

  localparam int QW = 6;
  localparam int DW = 5;
  localparam int AW = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [QW-1:0]    QIN;
  logic [DW-1:0]    DIN;
  logic [QW-1:0]    RIN;
  logic             busy;
  logic             done;
  logic [QW+DW-1:0] AOUT;
  logic             overflow;
`ifdef QMULT_REMCHK_EN
  logic             remerr;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Results of the most recent run_op call.
  int   op_lat;
  logic op_busy_calc;

  quotient_multiplier #(.QW(QW), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .QIN      (QIN),
    .DIN      (DIN),
    .RIN      (RIN),
    .busy     (busy),
    .done     (done),
    .AOUT     (AOUT),
    .overflow (overflow)
`ifdef QMULT_REMCHK_EN
    ,
    .remerr   (remerr)
`endif
  );

  always #5 clk = ~clk;

  // Pulse start for one edge, then count edges until done (bounded; -1 on timeout).
  // Returns at the negedge where done was first seen high.
  task automatic run_op(input int q, input int d, input int r);
    @(negedge clk);
    QIN = QW'(q); DIN = DW'(d); RIN = QW'(r); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_busy_calc = busy;
    op_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        op_lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; QIN = '0; DIN = '0; RIN = '0;
    #12;
    n_cmp++; if ({busy, done, overflow} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags: got busy=%b done=%b ovf=%b, want 000", busy, done, overflow); end
    n_cmp++; if (AOUT !== 11'd0) begin n_err++;
      $display("FAIL reset_aout: got %0d, want 0", AOUT); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_op(21, 23, 20);
    n_cmp++; if (op_busy_calc !== 1'b1) begin n_err++;
      $display("FAIL basic_busy_calc: got %b, want 1", op_busy_calc); end
    n_cmp++; if (op_lat !== 5) begin n_err++;
      $display("FAIL basic_latency: got %0d edges after accept, want 5", op_lat); end
    n_cmp++; if (AOUT !== 11'd503) begin n_err++;
      $display("FAIL basic_aout: got %0d, want 503", AOUT); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++;
      $display("FAIL basic_ovf: got %b, want 0", overflow); end
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++;
      $display("FAIL basic_after_done: got busy=%b done=%b, want 00", busy, done); end
    n_cmp++; if (AOUT !== 11'd503) begin n_err++;
      $display("FAIL basic_aout_hold: got %0d, want 503", AOUT); end
  endtask

  task automatic test_overflow();
    run_op(63, 31, 63);
    n_cmp++; if (AOUT !== 11'd2016 || overflow !== 1'b1) begin n_err++;
      $display("FAIL ovf_max: got aout=%0d ovf=%b, want 2016/1", AOUT, overflow); end
    run_op(45, 22, 10);
    n_cmp++; if (AOUT !== 11'd1000 || overflow !== 1'b0) begin n_err++;
      $display("FAIL ovf_below: got aout=%0d ovf=%b, want 1000/0", AOUT, overflow); end
  endtask

  task automatic test_zero();
    run_op(0, 0, 5);
    n_cmp++; if (op_lat !== 5) begin n_err++;
      $display("FAIL zero_latency: got %0d, want 5", op_lat); end
    n_cmp++; if (AOUT !== 11'd5) begin n_err++;
      $display("FAIL zero_aout: got %0d, want 5", AOUT); end
    run_op(31, 1, 0);
    n_cmp++; if (AOUT !== 11'd31) begin n_err++;
      $display("FAIL d1_aout: got %0d, want 31", AOUT); end
  endtask

  // start high for edges e0..e9 while QIN = k+1 before edge k (D=3, R=2).
  // Accepts at e0 (Q=1 -> 5) and, after DONE, at e7 (Q=8 -> 26).
  task automatic test_start_held();
    int   n_done = 0;
    logic [QW+DW-1:0] first_a = '0;
    logic [QW+DW-1:0] second_a = '0;
    logic [QW+DW-1:0] mid_a = '0;
    DIN = 5'd3; RIN = 6'd2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) first_a = AOUT;
        if (n_done == 2) second_a = AOUT;
      end
      if (k == 10) mid_a = AOUT;
      start = (k < 10);
      QIN   = QW'(k + 1);
    end
    start = 1'b0;
    n_cmp++; if (n_done !== 2) begin n_err++;
      $display("FAIL held_done_count: got %0d, want 2", n_done); end
    n_cmp++; if (first_a !== 11'd5) begin n_err++;
      $display("FAIL held_first: got %0d, want 5", first_a); end
    n_cmp++; if (mid_a !== 11'd5) begin n_err++;
      $display("FAIL held_stable: got %0d, want 5", mid_a); end
    n_cmp++; if (second_a !== 11'd26) begin n_err++;
      $display("FAIL held_second: got %0d, want 26", second_a); end
  endtask

  task automatic test_async_reset();
    int n_done = 0;
    @(negedge clk);
    QIN = 6'd21; DIN = 5'd23; RIN = 6'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({busy, done, overflow} !== 3'b000 || AOUT !== 11'd0) begin n_err++;
      $display("FAIL areset_immediate: got busy=%b done=%b ovf=%b aout=%0d, want 0", busy, done, overflow, AOUT); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_err++;
      $display("FAIL areset_no_resume: got %0d active cycles, want 0", n_done); end
    run_op(45, 22, 10);
    n_cmp++; if (op_lat !== 5 || AOUT !== 11'd1000) begin n_err++;
      $display("FAIL areset_fresh: got lat=%0d aout=%0d, want 5/1000", op_lat, AOUT); end
  endtask

`ifdef QMULT_REMCHK_EN
  task automatic test_remchk();
    run_op(3, 5, 7);
    n_cmp++; if (AOUT !== 11'd22 || remerr !== 1'b1) begin n_err++;
      $display("FAIL remchk_hi: got aout=%0d remerr=%b, want 22/1", AOUT, remerr); end
    run_op(3, 5, 4);
    n_cmp++; if (AOUT !== 11'd19 || remerr !== 1'b0) begin n_err++;
      $display("FAIL remchk_lo: got aout=%0d remerr=%b, want 19/0", AOUT, remerr); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero();
    test_start_held();
    test_async_reset();
`ifdef QMULT_REMCHK_EN
    test_remchk();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quotient_multiplier.md
Name: quotient_multiplier

Overview:
- Sequential shift-add multiply-accumulate block. Computes A = Q*D + R, the inverse of the divider datapath.
- Rebuilds the dividend from a quotient, divisor and remainder. Used as the self-check and inverse path beside the divider.
- Own controller FSM plus datapath registers. One operation in flight at a time; start/done handshake.

Parameters:
- QW, 6, quotient and remainder width (multiplicand and addend)
- DW, 5, divisor width (multiplier); also the iteration count
- AW, 10, dividend width used for the overflow check; requires AW <= QW+DW

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- QIN  in  QW  quotient operand, captured on the accepting edge
- DIN  in  DW  divisor operand, captured on the accepting edge
- RIN  in  QW  remainder operand, captured on the accepting edge
- busy  out  1  high in CALC and DONE states
- done  out  1  one-cycle completion pulse
- AOUT  out  QW+DW  reconstructed dividend Q*D+R
- overflow  out  1  AOUT >= 2^AW (does not fit a divider dividend)

Behaviour:
- Reset (rst=0, any time, mid-operation included): state IDLE immediately, all registers cleared. busy=0, done=0, AOUT=0, overflow=0. No operation resumes after reset release.
- IDLE:
  - start=1 at a rising edge: P<=RIN zero-extended, M<=QIN zero-extended to QW+DW, B<=DIN, cnt<=0, go to CALC.
  - start=0: hold. AOUT and overflow keep the last result.
- CALC, each edge:
  - if B[0], P<=P+M; then M<=M<<1, B<=B>>1, cnt<=cnt+1.
  - After exactly DW iterations (edge with cnt=DW-1), go to DONE. Register AOUT<=final P and overflow<=(final P >= 2^AW) on that same edge.
- DONE: done=1 for exactly one cycle, busy=1. Next edge returns to IDLE. Start is ignored in DONE.
- Latency: done is high in the cycle after the (DW+1)th rising edge counted from the start-accepting edge. Default: the accepting edge, then 5 CALC edges, then done for 1 cycle. Earliest next accept is the edge after the done cycle.
- Width rules:
  - Arithmetic is unsigned, QW+DW bits.
  - Max result (2^QW-1)*2^DW fits, so no internal carry is lost.
  - overflow is informative only; AOUT is always the exact value.
- start while busy=1: ignored. Operand changes during CALC have no effect, since operands are latched.
- AOUT and overflow change only on the completion edge or reset. They are stable from done until the next completion.
- D=0 or Q=0: full DW iterations still run; AOUT=R. Latency is fixed, with no early exit.
- Encode the FSM with 2-bit state: IDLE=0, CALC=1, DONE=2. Unused code 3 goes to IDLE on the next edge with outputs cleared.

Optional Feature:
- Macro: QMULT_REMCHK_EN
- Defined:
  - Adds output remerr (1 bit). It is registered on the completion edge as (R >= D) using the latched operands, so R >= D with D=0 also flags.
  - Cleared by reset. Held like AOUT.
- Undefined: no remerr port and no comparator. All other behaviour is identical.

Test Plan:
- Q=21, D=23, R=20, start pulse -> done 1 cycle at edge 6 after accept; AOUT=503, overflow=0, busy low after done.
- Q=63, D=31, R=63 -> AOUT=2016, overflow=1. Then Q=45, D=22, R=10 -> AOUT=1000, overflow=0 (boundary below 1024).
- Q=0, D=0, R=5 -> AOUT=5 after the same fixed latency. Q=31, D=1, R=0 -> AOUT=31.
- start held high for 10 cycles with changing QIN -> exactly one operation using the operands at the accepting edge. A second result only follows from a new accept after DONE.
- rst=0 asserted asynchronously mid-CALC (between edges) -> busy, done, AOUT and overflow go to 0 immediately. No done after release; a fresh start then completes normally.
- With QMULT_REMCHK_EN: Q=3, D=5, R=7 -> AOUT=22, remerr=1. Q=3, D=5, R=4 -> AOUT=19, remerr=0.
